// File: rtl/depp_reg_ctrl_if.sv
// Internal single-master register bus shared by the DEPP controller and the
// register decode / peripheral blocks.
interface depp_reg_ctrl_if;
  logic [7:0] o_bus_addr;
  logic [7:0] o_bus_wdata;
  logic       o_bus_we;
  logic       o_bus_req;
  logic       i_bus_ack;
  logic [7:0] i_bus_rdata;
  logic       o_bus_err;

  modport master (
    output o_bus_addr,
    output o_bus_wdata,
    output o_bus_we,
    output o_bus_req,
    output o_bus_err,
    input  i_bus_ack,
    input  i_bus_rdata
  );

  modport slave (
    input  o_bus_addr,
    input  o_bus_wdata,
    input  o_bus_we,
    input  o_bus_req,
    input  o_bus_err,
    output i_bus_ack,
    output i_bus_rdata
  );
endinterface

// File: rtl/depp_reg_ctrl.sv
// DEPP slave controller: turns host EPP address/data strobes into req/ack
// transfers on the internal register bus, stretching wait until completion.
module depp_reg_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 255,
  parameter int         AUTO_INC    = 1,
  parameter logic [7:0] ERR_DATA    = 8'hEE
) (
  input  logic           i_clk_8mhz,
  input  logic           i_rst,
  input  logic           i_depp_astb_n,
  input  logic           i_depp_dstb_n,
  input  logic           i_depp_write_n,
  input  logic [7:0]     i_depp_data,
  output logic [7:0]     o_depp_data,
  output logic           o_depp_data_oe,
  output logic           o_depp_wait,
  depp_reg_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    BUS_REQ,
    HOLD
  } state_t;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] astbSync_q;
  logic [SYNC_STAGES-1:0] dstbSync_q;
  logic [SYNC_STAGES-1:0] writeSync_q;

  state_t     state_q,  state_d;
  logic [7:0] addr_q,   addr_d;
  logic [7:0] wdata_q,  wdata_d;
  logic       we_q,     we_d;
  logic       req_q,    req_d;
  logic       err_q,    err_d;
  logic [7:0] cnt_q,    cnt_d;
  logic       armed_q,  armed_d;
  logic [7:0] rdData_q, rdData_d;
  logic       oe_q,     oe_d;
  logic       wait_q,   wait_d;

  logic astbLow;
  logic dstbLow;
  logic bothHigh;
  logic hostWrite;
  logic reqDone;

  // Synchronisers reset to the asserted (low) level so a strobe held low
  // across reset can never look like a fresh edge afterwards.
  always_ff @(posedge i_clk_8mhz or posedge i_rst) begin
    if (i_rst) begin
      astbSync_q  <= '0;
      dstbSync_q  <= '0;
      writeSync_q <= '0;
    end else begin
      astbSync_q  <= {astbSync_q[SYNC_STAGES-2:0],  i_depp_astb_n};
      dstbSync_q  <= {dstbSync_q[SYNC_STAGES-2:0],  i_depp_dstb_n};
      writeSync_q <= {writeSync_q[SYNC_STAGES-2:0], i_depp_write_n};
    end
  end

  assign astbLow   = ~astbSync_q[SYNC_STAGES-1];
  assign dstbLow   = ~dstbSync_q[SYNC_STAGES-1];
  assign bothHigh  = ~astbLow & ~dstbLow;
  assign hostWrite = ~writeSync_q[SYNC_STAGES-1];
  assign reqDone   = bus.i_bus_ack || (cnt_q == TimeoutLast);

  always_ff @(posedge i_clk_8mhz or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      rdData_q <= '0;
      oe_q     <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      req_q    <= req_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      rdData_q <= rdData_d;
      oe_q     <= oe_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    req_d    = req_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    rdData_d = rdData_q;
    oe_d     = oe_q;
    wait_d   = wait_q;

    if (bothHigh) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (armed_q && astbLow) begin
          state_d = ADDR;
          armed_d = 1'b0;
        end else if (armed_q && dstbLow) begin
          state_d = BUS_REQ;
          armed_d = 1'b0;
          req_d   = 1'b1;
          cnt_d   = '0;
          we_d    = hostWrite;
          if (hostWrite) wdata_d = i_depp_data;
        end
      end

      ADDR: begin
        if (hostWrite) begin
          addr_d = i_depp_data;
          err_d  = 1'b0;
        end else begin
          rdData_d = addr_q;
          oe_d     = 1'b1;
        end
        wait_d  = 1'b1;
        state_d = HOLD;
      end

      BUS_REQ: begin
        if (reqDone) begin
          if (!bus.i_bus_ack) err_d = 1'b1;
          if (!we_q) begin
            rdData_d = bus.i_bus_ack ? bus.i_bus_rdata : ERR_DATA;
            oe_d     = 1'b1;
          end
          if (AUTO_INC != 0) addr_d = addr_q + 8'd1;
          req_d   = 1'b0;
          wait_d  = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HOLD: begin
        if (bothHigh) begin
          wait_d  = 1'b0;
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_depp_data     = rdData_q;
  assign o_depp_data_oe  = oe_q;
  assign o_depp_wait     = wait_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_wdata = wdata_q;
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_req   = req_q;
  assign bus.o_bus_err   = err_q;

endmodule

// File: tb/tb_depp_reg_ctrl.sv
// Directed bench for depp_reg_ctrl with a scoreboard of expected bus and
// read-back values.
`timescale 1ns/1ns
module tb_depp_reg_ctrl;

  logic       clk;
  logic       rst;
  logic       astbN;
  logic       dstbN;
  logic       writeN;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       dataOe;
  logic       waitOut;

  int errors = 0;
  int checks = 0;
  int reqRises = 0;
  logic reqPrev = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sbQ[$];

  depp_reg_ctrl_if busIf ();

  depp_reg_ctrl #(
    .SYNC_STAGES(2),
    .TIMEOUT    (8),
    .AUTO_INC   (1),
    .ERR_DATA   (8'hEE)
  ) dut (
    .i_clk_8mhz    (clk),
    .i_rst         (rst),
    .i_depp_astb_n (astbN),
    .i_depp_dstb_n (dstbN),
    .i_depp_write_n(writeN),
    .i_depp_data   (dataIn),
    .o_depp_data   (dataOut),
    .o_depp_data_oe(dataOe),
    .o_depp_wait   (waitOut),
    .bus           (busIf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busIf.o_bus_req && !reqPrev) reqRises++;
    reqPrev = busIf.o_bus_req;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic d, input logic w, input logic [7:0] v);
    astbN  = a;
    dstbN  = d;
    writeN = w;
    dataIn = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboardEmpty observed=%0h expected=none", obs);
    end else begin
      e = sbQ.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  task automatic waitReq(output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 30) begin
      if (busIf.o_bus_req) ok = 1'b1;
      else begin
        tick(1);
        i++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("[TB] FAIL waitReq observed=no_req expected=req_within_30");
    end
  endtask

  task automatic endStrobe();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    tick(2);
    checkOutput("waitHeld", waitOut, 1);
    tick(1);
    checkOutput("waitFall", waitOut, 0);
    checkOutput("oeFall", dataOe, 0);
    tick(1);
  endtask

  task automatic addrCycle(input bit isWrite, input logic [7:0] val);
    if (!isWrite) pushExp("addrReadData", val);
    applyStimulus(1'b0, 1'b1, ~isWrite, isWrite ? val : 8'h00);
    tick(2);
    checkOutput("addrWaitEarly", waitOut, 0);
    tick(2);
    checkOutput("addrWaitRise", waitOut, 1);
    checkOutput("addrNoReq", busIf.o_bus_req, 0);
    if (isWrite) begin
      checkOutput("addrReg", busIf.o_bus_addr, val);
      checkOutput("addrWriteOe", dataOe, 0);
    end else begin
      checkOutput("addrReadOe", dataOe, 1);
      popCheck(dataOut);
    end
    endStrobe();
  endtask

  task automatic dataCycle(input bit isWrite, input logic [7:0] wval, input int ackCycle,
                           input logic [7:0] rval, input logic [7:0] expAddr,
                           input int expCycles, input logic [7:0] expRead);
    int n;
    int rises0;
    bit ok;
    logic [7:0] nextAddr;
    nextAddr = expAddr + 8'd1;
    pushExp("busAddr", expAddr);
    pushExp("busWe", isWrite);
    if (isWrite) pushExp("busWdata", wval);
    else pushExp("readData", expRead);
    rises0 = reqRises;
    applyStimulus(1'b1, 1'b0, ~isWrite, wval);
    waitReq(ok);
    if (ok) begin
      popCheck(busIf.o_bus_addr);
      popCheck(busIf.o_bus_we);
      if (isWrite) popCheck(busIf.o_bus_wdata);
      n = 0;
      while (busIf.o_bus_req && n < 300) begin
        n++;
        if (n == ackCycle) begin
          busIf.i_bus_ack   = 1'b1;
          busIf.i_bus_rdata = rval;
        end
        tick(1);
        busIf.i_bus_ack   = 1'b0;
        busIf.i_bus_rdata = 8'h00;
      end
      checkOutput("reqCycles", n, expCycles);
      checkOutput("dataWaitRise", waitOut, 1);
      if (!isWrite) begin
        checkOutput("dataReadOe", dataOe, 1);
        popCheck(dataOut);
      end
      checkOutput("addrAfterData", busIf.o_bus_addr, nextAddr);
      checkOutput("oneReqPerStrobe", reqRises - rises0, 1);
    end else begin
      sbQ.delete();
    end
    endStrobe();
  endtask

  initial begin
    int rises0;
    bit ok;
    busIf.i_bus_ack   = 1'b0;
    busIf.i_bus_rdata = 8'h00;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    rst = 1'b1;
    #22;
    checkOutput("rstWait", waitOut, 0);
    checkOutput("rstOe", dataOe, 0);
    checkOutput("rstData", dataOut, 0);
    checkOutput("rstReq", busIf.o_bus_req, 0);
    checkOutput("rstErr", busIf.o_bus_err, 0);
    checkOutput("rstAddr", busIf.o_bus_addr, 0);
    checkOutput("rstWdata", busIf.o_bus_wdata, 0);
    checkOutput("rstWe", busIf.o_bus_we, 0);
    rst = 1'b0;
    tick(4);

    $display("[TB] address write / read");
    addrCycle(1'b1, 8'h3C);
    addrCycle(1'b0, 8'h3C);

    $display("[TB] data write with late ack");
    dataCycle(1'b1, 8'hA5, 4, 8'h00, 8'h3C, 4, 8'h00);
    checkOutput("errAfterWrite", busIf.o_bus_err, 0);

    $display("[TB] data read with address wrap");
    addrCycle(1'b1, 8'hFF);
    dataCycle(1'b0, 8'h00, 1, 8'h5A, 8'hFF, 1, 8'h5A);

    $display("[TB] read timeout");
    addrCycle(1'b1, 8'h10);
    dataCycle(1'b0, 8'h00, 0, 8'h00, 8'h10, 8, 8'hEE);
    checkOutput("errSticky", busIf.o_bus_err, 1);
    addrCycle(1'b1, 8'h20);
    checkOutput("errCleared", busIf.o_bus_err, 0);

    $display("[TB] both strobes low");
    rises0 = reqRises;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h42);
    tick(4);
    checkOutput("bothWaitRise", waitOut, 1);
    checkOutput("bothAddr", busIf.o_bus_addr, 8'h42);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h42);
    tick(10);
    checkOutput("bothWaitHeld", waitOut, 1);
    checkOutput("bothNoReq", reqRises - rises0, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    tick(3);
    checkOutput("bothWaitFall", waitOut, 0);
    tick(6);
    checkOutput("bothNoLateReq", reqRises - rises0, 0);

    $display("[TB] reset during bus request");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    waitReq(ok);
    rst = 1'b1;
    #1;
    checkOutput("midRstReq", busIf.o_bus_req, 0);
    checkOutput("midRstWait", waitOut, 0);
    checkOutput("midRstOe", dataOe, 0);
    tick(2);
    rst = 1'b0;
    rises0 = reqRises;
    tick(10);
    checkOutput("postRstNoReq", reqRises - rises0, 0);
    checkOutput("postRstAddr", busIf.o_bus_addr, 0);
    checkOutput("postRstWait", waitOut, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    tick(4);
    dataCycle(1'b0, 8'h00, 2, 8'h77, 8'h00, 2, 8'h77);

    checkOutput("scoreboardDrained", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
